// File: rtl/nibble_serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// nibble_serial_adder_ctrl
//
// Wide add/subtract built from one 4-bit ripple adder that is reused once per
// clock, least significant nibble first. Operands are captured on an accepted
// start, the carry is chained between nibbles through a register, and the
// full-width result is presented together with a one-cycle done pulse.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset; aborts any operation in flight
//   start      request, only looked at while idle
//   sub        0 = a + b, 1 = a - b (captured with the operands)
//   a, b       W-bit operands, W = 4*NIBBLES (captured on accepted start)
//   busy       high while nibbles are being processed
//   done       one-cycle pulse; sum/carry_out/overflow valid
//   sum        W-bit result register
//   carry_out  final adder carry (for subtraction 1 means no borrow)
//   overflow   two's-complement signed overflow
// -----------------------------------------------------------------------------

// 4-bit ripple-carry adder shared by the controller below.
module four_bit_full_adder (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       cout
);
   logic [4:0] c;

   assign c[0] = cin;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_bit
         assign sum[gi]  = a[gi] ^ b[gi] ^ c[gi];
         assign c[gi+1]  = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
      end
   endgenerate

   assign cout = c[4];
endmodule

module nibble_serial_adder_ctrl #(
   parameter int NIBBLES = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 sub,
   input  logic [4*NIBBLES-1:0] a,
   input  logic [4*NIBBLES-1:0] b,
   output logic                 busy,
   output logic                 done,
   output logic [4*NIBBLES-1:0] sum,
   output logic                 carry_out,
   output logic                 overflow
);
   localparam int W     = 4 * NIBBLES;
   localparam int IDX_W = $clog2(NIBBLES);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]       state_reg;
   logic [IDX_W-1:0] idx_reg;
   logic             carry_reg;
   logic [W-1:0]     a_reg;
   // Holds the effective B operand (already inverted for subtraction), so
   // the subtract flag itself only needs to live on as the initial carry.
   logic [W-1:0]     b_reg;
   logic [W-1:0]     sum_reg;
   logic             carry_out_reg;
   logic             overflow_reg;

   logic [IDX_W+1:0] bit_base;
   logic [3:0]       add_a;
   logic [3:0]       add_b;
   logic [3:0]       add_sum;
   logic             add_cout;
   logic             last_nibble;

   // Bit offset of the current nibble: idx * 4.
   assign bit_base    = {idx_reg, 2'b00};
   assign add_a       = a_reg[bit_base +: 4];
   assign add_b       = b_reg[bit_base +: 4];
   assign last_nibble = (idx_reg == IDX_W'(NIBBLES - 1));

   four_bit_full_adder u_adder (
      .a    (add_a),
      .b    (add_b),
      .cin  (carry_reg),
      .sum  (add_sum),
      .cout (add_cout)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         idx_reg       <= '0;
         carry_reg     <= 1'b0;
         a_reg         <= '0;
         b_reg         <= '0;
         sum_reg       <= '0;
         carry_out_reg <= 1'b0;
         overflow_reg  <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start) begin
                  a_reg         <= a;
                  b_reg         <= b ^ {W{sub}};
                  // Subtraction is a + ~b + 1: the +1 enters as carry-in.
                  carry_reg     <= sub;
                  idx_reg       <= '0;
                  sum_reg       <= '0;
                  carry_out_reg <= 1'b0;
                  overflow_reg  <= 1'b0;
                  state_reg     <= RUN;
               end
            end
            RUN: begin
               sum_reg[bit_base +: 4] <= add_sum;
               carry_reg              <= add_cout;
               if (last_nibble) begin
                  idx_reg       <= '0;
                  carry_out_reg <= add_cout;
                  // Signed overflow: operands share a sign that the result lost.
                  // add_sum[3] is the result MSB being written this edge.
                  overflow_reg  <= (a_reg[W-1] == b_reg[W-1]) &&
                                   (add_sum[3] != a_reg[W-1]);
                  state_reg     <= DONE;
               end else begin
                  idx_reg <= idx_reg + IDX_W'(1);
               end
            end
            DONE: begin
               state_reg <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign busy      = (state_reg == RUN);
   assign done      = (state_reg == DONE);
   assign sum       = sum_reg;
   assign carry_out = carry_out_reg;
   assign overflow  = overflow_reg;
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for nibble_serial_adder_ctrl (NIBBLES = 4, W = 16).
// Stimulus pushes expected results into a scoreboard queue; a monitor process
// pops and compares whenever done is high. Timing/handshake observations made
// by the stimulus are posted to a second queue that the monitor also checks,
// so all counting happens in one process.
// -----------------------------------------------------------------------------
module tb_nibble_serial_adder_ctrl;
   localparam int NIBBLES = 4;
   localparam int W       = 4 * NIBBLES;

   logic         clk;
   logic         rst;
   logic         start;
   logic         sub;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         carry_out;
   logic         overflow;

   typedef struct {
      logic [W-1:0] sum;
      logic         c;
      logic         v;
   } exp_t;

   typedef struct {
      string       name;
      logic [31:0] act;
      logic [31:0] exp;
   } chk_t;

   exp_t sb_q[$];
   chk_t chk_q[$];

   int checks = 0;
   int errors = 0;
   int txn_num = 0;
   int cyc = 0;
   int last_done = -1;
   bit b2b_mode = 0;

   nibble_serial_adder_ctrl #(.NIBBLES(NIBBLES)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .sub       (sub),
      .a         (a),
      .b         (b),
      .busy      (busy),
      .done      (done),
      .sum       (sum),
      .carry_out (carry_out),
      .overflow  (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void push_chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      chk_t c;
      c.name = n;
      c.act  = act;
      c.exp  = exp;
      chk_q.push_back(c);
   endfunction

   function automatic void push_exp(input logic [W-1:0] s, input logic c, input logic v);
      exp_t e;
      e.sum = s;
      e.c   = c;
      e.v   = v;
      sb_q.push_back(e);
   endfunction

   // Monitor: the only process that updates checks/errors.
   initial begin
      chk_t c;
      exp_t e;
      forever begin
         @(negedge clk);
         cyc++;
         while (chk_q.size() > 0) begin
            c = chk_q.pop_front();
            checks++;
            if (c.act !== c.exp) begin
               errors++;
               $display("FAIL %s: got %0h, expected %0h", c.name, c.act, c.exp);
            end
         end
         if (done === 1'b1) begin
            txn_num++;
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no pending result", cyc);
            end else begin
               e = sb_q.pop_front();
               $display("txn %0d: sum=%h carry_out=%b overflow=%b (expect %h %b %b)",
                        txn_num, sum, carry_out, overflow, e.sum, e.c, e.v);
               checks++;
               if (sum !== e.sum) begin
                  errors++;
                  $display("FAIL sum: got %h, expected %h", sum, e.sum);
               end
               checks++;
               if (carry_out !== e.c) begin
                  errors++;
                  $display("FAIL carry_out: got %b, expected %b", carry_out, e.c);
               end
               checks++;
               if (overflow !== e.v) begin
                  errors++;
                  $display("FAIL overflow: got %b, expected %b", overflow, e.v);
               end
            end
            if (b2b_mode) begin
               if (last_done >= 0) begin
                  checks++;
                  if (cyc - last_done != 6) begin
                     errors++;
                     $display("FAIL done_spacing: got %0d cycles, expected 6", cyc - last_done);
                  end
               end
               last_done = cyc;
            end
         end
         if (!b2b_mode) last_done = -1;
      end
   end

   // One isolated operation with latency/busy-width checks. Operand inputs are
   // scrambled right after acceptance to show they were latched.
   task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv,
                        input logic [W-1:0] es, input logic ec, input logic ev);
      int busy_cnt;
      @(negedge clk);
      a = av; b = bv; sub = sv; start = 1'b1;
      push_exp(es, ec, ev);
      @(negedge clk);
      start = 1'b0; a = ~av; b = ~bv; sub = ~sv;
      busy_cnt = 0;
      for (int k = 1; k <= 5; k++) begin
         if (k > 1) @(negedge clk);
         busy_cnt += int'(busy);
         if (k == 5) push_chk("done_latency", 32'(done), 32'd1);
      end
      push_chk("busy_cycles", 32'(busy_cnt), 32'd4);
      @(negedge clk);
      push_chk("done_width", 32'(done), 32'd0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
      repeat (3) @(negedge clk);
      push_chk("reset_busy", 32'(busy), 32'd0);
      push_chk("reset_done", 32'(done), 32'd0);
      push_chk("reset_sum", 32'(sum), 32'd0);
      push_chk("reset_carry", 32'(carry_out), 32'd0);
      push_chk("reset_ovf", 32'(overflow), 32'd0);
      rst = 1'b0;

      // Directed vectors (hand-computed).
      do_op(16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0);
      do_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
      do_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
      do_op(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      do_op(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);

      // Start held high with operand change during RUN: one result for the
      // original operands, the next op accepted on the first IDLE cycle.
      @(negedge clk);
      a = 16'h0001; b = 16'h0001; sub = 1'b0; start = 1'b1;
      push_exp(16'h0002, 1'b0, 1'b0);
      @(negedge clk);
      a = 16'hAAAA;
      push_exp(16'hAAAB, 1'b0, 1'b0);
      for (int k = 2; k <= 6; k++) begin
         @(negedge clk);
         if (k == 5) push_chk("hold_done", 32'(done), 32'd1);
         if (k == 6) push_chk("hold_idle_busy", 32'(busy), 32'd0);
      end
      @(negedge clk);
      push_chk("accept_first_idle", 32'(busy), 32'd1);
      start = 1'b0;
      repeat (6) @(negedge clk);

      // Reset on the second RUN cycle aborts with no done.
      @(negedge clk);
      a = 16'h1234; b = 16'h1111; sub = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      push_chk("abort_in_run", 32'(busy), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      push_chk("abort_busy", 32'(busy), 32'd0);
      push_chk("abort_done", 32'(done), 32'd0);
      push_chk("abort_sum", 32'(sum), 32'd0);
      push_chk("abort_carry", 32'(carry_out), 32'd0);
      push_chk("abort_ovf", 32'(overflow), 32'd0);
      repeat (8) @(negedge clk);
      do_op(16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0);

      // Back-to-back with start held high; operands changed in IDLE cycles.
      b2b_mode = 1'b1;
      @(negedge clk);
      a = 16'h1111; b = 16'h2222; sub = 1'b0; start = 1'b1;
      push_exp(16'h3333, 1'b0, 1'b0);
      repeat (6) @(negedge clk);
      a = 16'h0010; b = 16'h0001; sub = 1'b1;
      push_exp(16'h000F, 1'b1, 1'b0);
      repeat (6) @(negedge clk);
      a = 16'h8000; b = 16'h8000; sub = 1'b0;
      push_exp(16'h0000, 1'b1, 1'b1);
      repeat (6) @(negedge clk);
      a = 16'hAAAA; b = 16'h5555; sub = 1'b0;
      push_exp(16'hFFFF, 1'b0, 1'b0);
      @(negedge clk);
      start = 1'b0;
      repeat (6) @(negedge clk);
      b2b_mode = 1'b0;

      // Bounded drain of outstanding expectations.
      for (int k = 0; k < 100 && (sb_q.size() != 0 || chk_q.size() != 0); k++)
         @(negedge clk);
      push_chk("drain_pending", 32'(sb_q.size()), 32'd0);
      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion before 200000");
      $fatal(1);
   end
endmodule
